// File: rtl/sram_responder_if.sv
// ---------------------------------------------------------------------------
// sram_responder_if
//
// Pin-level bundle of an asynchronous SRAM device. Every strobe is active-low.
//
// Signals:
//   address_pins   word address, driven by the controller
//   data_pins_in   write data, driven by the controller
//   OE / WE / CS   output enable, write enable, chip select (all low active)
//   data_pins_out  read data, driven by the memory
//   data_drive_en  high while the memory drives the data pins
//
// Modports:
//   master  the controller side: drives address, write data and strobes
//   slave   the memory side: drives read data and its drive enable
//
// The pins carry no handshake. The memory samples the strobes on every
// rising clock edge and acts on whatever level it sees there. Read data is
// valid whenever data_drive_en is high.
// ---------------------------------------------------------------------------
interface sram_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] address_pins;
  logic [DATA_W-1:0] data_pins_in;
  logic              OE;
  logic              WE;
  logic              CS;
  logic [DATA_W-1:0] data_pins_out;
  logic              data_drive_en;

  modport master (
    output address_pins,
    output data_pins_in,
    output OE,
    output WE,
    output CS,
    input  data_pins_out,
    input  data_drive_en
  );

  modport slave (
    input  address_pins,
    input  data_pins_in,
    input  OE,
    input  WE,
    input  CS,
    output data_pins_out,
    output data_drive_en
  );
endinterface

// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
//
// Synthesizable stand-in for a (2**ADDR_W) x DATA_W asynchronous SRAM. It is
// the responding end of the SRAM pin interface. Strobes sampled on each
// rising clock edge turn into memory writes and read-data drive. The block
// also counts completed accesses and flags WE/OE conflicts.
//
// Ports:
//   clock          system clock; all state changes on the rising edge
//   reset          asynchronous, active-low reset
//   sram           slave end of the SRAM pin bundle
//   write_count    completed write accesses (saturating)
//   read_count     completed read accesses (saturating)
//   conflict       sticky; WE and OE were sampled low together with CS low
//   dbg_state      current FSM state, for observation only
//
// Read data is always mem[address_pins] and is purely combinational. Only
// data_drive_en decides whether the controller should treat it as valid.
// ---------------------------------------------------------------------------
module sram_responder #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 4,
  parameter int READ_LATENCY = 0,
  parameter int COUNT_W      = 16
) (
  input  logic               clock,
  input  logic               reset,
  sram_responder_if.slave    sram,
  output logic [COUNT_W-1:0] write_count,
  output logic [COUNT_W-1:0] read_count,
  output logic               conflict,
  output logic [1:0]         dbg_state
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int WAIT_W = 3;

  // Value loaded into the wait counter when a read is requested. With zero
  // latency there is no READ_WAIT state, and the constant is never used.
  localparam logic [WAIT_W-1:0] WAIT_INIT =
    (READ_LATENCY > 0) ? WAIT_W'(READ_LATENCY - 1) : '0;

  localparam logic               LAT0    = (READ_LATENCY == 0);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_HOLD = 2'd1,
    READ_WAIT  = 2'd2,
    READ_DRIVE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [COUNT_W-1:0]  wcnt_q, wcnt_d;
  logic [COUNT_W-1:0]  rcnt_q, rcnt_d;
  logic                conflict_q, conflict_d;

  logic                commit;
  logic                wcnt_inc;
  logic                rcnt_inc;
  logic                conflict_set;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                cs_n;
  logic                we_n;
  logic                oe_n;

  assign cs_n = sram.CS;
  assign we_n = sram.WE;
  assign oe_n = sram.OE;

  // -------------------------------------------------------------------------
  // Next-state decode. A deselected chip (CS high) always returns to IDLE,
  // and that check comes before any other decision.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    commit       = 1'b0;
    wcnt_inc     = 1'b0;
    rcnt_inc     = 1'b0;
    conflict_set = 1'b0;

    if (cs_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!we_n) begin
            // The write wins over a simultaneous OE. No read is started.
            commit       = 1'b1;
            wcnt_inc     = 1'b1;
            conflict_set = !oe_n;
            state_d      = WRITE_HOLD;
          end else if (!oe_n) begin
            if (LAT0) begin
              rcnt_inc = 1'b1;
              state_d  = READ_DRIVE;
            end else begin
              wait_d  = WAIT_INIT;
              state_d = READ_WAIT;
            end
          end
        end

        WRITE_HOLD: begin
          // One commit per WE pulse. A long pulse only waits here.
          if (we_n) begin
            state_d = IDLE;
          end
        end

        READ_WAIT: begin
          if (oe_n || !we_n) begin
            // An aborted read is not counted. WE during a wait is flagged
            // but is not written.
            conflict_set = !oe_n && !we_n;
            state_d      = IDLE;
          end else if (wait_q == '0) begin
            rcnt_inc = 1'b1;
            state_d  = READ_DRIVE;
          end else begin
            wait_d = wait_q - 1'b1;
          end
        end

        READ_DRIVE: begin
          if (oe_n) begin
            state_d = IDLE;
          end else if (!we_n) begin
            conflict_set = 1'b1;
            commit       = 1'b1;
            wcnt_inc     = 1'b1;
            state_d      = WRITE_HOLD;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    conflict_d = conflict_q | conflict_set;
    if (wcnt_inc && (wcnt_q != CNT_MAX)) begin
      wcnt_d = wcnt_q + 1'b1;
    end
    if (rcnt_inc && (rcnt_q != CNT_MAX)) begin
      rcnt_d = rcnt_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // FSM, counters and the conflict flag.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      conflict_q <= conflict_d;
    end
  end

  // -------------------------------------------------------------------------
  // Storage. Reset does not clear it. Commits are blocked while reset is
  // held, because the FSM sits in IDLE then and would otherwise act on the
  // pins.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (commit && reset) begin
      mem[sram.address_pins] <= sram.data_pins_in;
    end
  end

  assign sram.data_pins_out = mem[sram.address_pins];

  // The drive comes straight from the pins so that it drops in the same
  // cycle that CS or OE rises or WE falls. With zero latency it is already
  // high in IDLE, the cycle the read request appears. Reset forces it low
  // at once.
  assign sram.data_drive_en = reset & !cs_n & !oe_n & we_n &
                              ((state_q == READ_DRIVE) |
                               (LAT0 & (state_q == IDLE)));

  assign write_count = wcnt_q;
  assign read_count  = rcnt_q;
  assign conflict    = conflict_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_responder
//
// Two responders share one set of pins. dut0 uses zero read latency and
// 16-bit counters. dut1 uses a read latency of 2 and 4-bit counters, so its
// counters saturate quickly. A transaction-level model tracks the memory
// contents, access counts and the conflict flag of each device. For every
// cycle in which a device should drive, the model pushes the expected read
// data. A negedge monitor pops and compares whenever a device drives.
// ---------------------------------------------------------------------------
module tb_sram_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] p_addr = '0;
  logic [3:0] p_din  = '0;
  logic       p_cs   = 1'b1;
  logic       p_we   = 1'b1;
  logic       p_oe   = 1'b1;

  sram_responder_if #(.ADDR_W(8), .DATA_W(4)) if0 ();
  sram_responder_if #(.ADDR_W(8), .DATA_W(4)) if1 ();

  assign if0.address_pins = p_addr;
  assign if0.data_pins_in = p_din;
  assign if0.CS = p_cs;
  assign if0.WE = p_we;
  assign if0.OE = p_oe;
  assign if1.address_pins = p_addr;
  assign if1.data_pins_in = p_din;
  assign if1.CS = p_cs;
  assign if1.WE = p_we;
  assign if1.OE = p_oe;

  logic [15:0] wc0, rc0;
  logic [3:0]  wc1, rc1;
  logic        cf0, cf1;
  logic [1:0]  st0, st1;

  sram_responder #(.ADDR_W(8), .DATA_W(4), .READ_LATENCY(0), .COUNT_W(16)) dut0 (
    .clock(clk), .reset(rst_n), .sram(if0.slave),
    .write_count(wc0), .read_count(rc0), .conflict(cf0), .dbg_state(st0)
  );

  sram_responder #(.ADDR_W(8), .DATA_W(4), .READ_LATENCY(2), .COUNT_W(4)) dut1 (
    .clock(clk), .reset(rst_n), .sram(if1.slave),
    .write_count(wc1), .read_count(rc1), .conflict(cf1), .dbg_state(st1)
  );

  // ---------------- reference model ----------------
  int         rl   [2] = '{0, 2};
  int         cmax [2] = '{65535, 15};
  logic [3:0] mdl_mem [2][256];
  int         mwc [2];
  int         mrc [2];
  int         mcf [2];

  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // A device drives on the request cycle when its latency is zero. With a
  // latency L > 0 it drives only after the request edge plus L wait edges.
  function automatic int skip(input int d);
    return (rl[d] == 0) ? 0 : rl[d] + 1;
  endfunction

  task automatic push(input int d, input logic [3:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  task automatic inc_w(input int d);
    if (mwc[d] < cmax[d]) mwc[d]++;
  endtask

  task automatic inc_r(input int d);
    if (mrc[d] < cmax[d]) mrc[d]++;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (if0.data_drive_en) begin
      if (exp_q0.size() == 0) flag_fail("drive0_unexpected");
      else check("rdata0", if0.data_pins_out, exp_q0.pop_front());
    end
    if (if1.data_drive_en) begin
      if (exp_q1.size() == 0) flag_fail("drive1_unexpected");
      else check("rdata1", if1.data_pins_out, exp_q1.pop_front());
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc(input logic cs, input logic we, input logic oe,
                     input logic [7:0] a, input logic [3:0] d);
    @(posedge clk);
    #1;
    p_cs = cs; p_we = we; p_oe = oe; p_addr = a; p_din = d;
  endtask

  // One deselected cycle, followed by a check of every register against the model.
  task automatic idle_check();
    cyc(1'b1, 1'b1, 1'b1, 8'($urandom), 4'($urandom));
    @(negedge clk);
    #1;
    check("missed_drive0", exp_q0.size(), 0);
    check("missed_drive1", exp_q1.size(), 0);
    exp_q0.delete();
    exp_q1.delete();
    check("write_count0", wc0, mwc[0]);
    check("read_count0",  rc0, mrc[0]);
    check("conflict0",    cf0, mcf[0]);
    check("write_count1", wc1, mwc[1]);
    check("read_count1",  rc1, mrc[1]);
    check("conflict1",    cf1, mcf[1]);
  endtask

  // A WE pulse of w cycles, then one more cycle with CS low and WE high.
  // Only the first cycle's address and data are committed.
  task automatic do_write(input logic [7:0] a, input logic [3:0] d, input int w, input bit wiggle);
    for (int i = 0; i < w; i++) begin
      cyc(1'b0, 1'b0, 1'b1, (i == 0 || !wiggle) ? a : 8'($urandom), 4'(d + i));
    end
    cyc(1'b0, 1'b1, 1'b1, a, d);
    for (int dd = 0; dd < 2; dd++) begin
      mdl_mem[dd][a] = d;
      inc_w(dd);
    end
    idle_check();
  endtask

  // n cycles with OE low. The last cycle may be followed by a cycle with both
  // WE and OE low (fin), which writes cd to ca. n == 0 with fin is a plain
  // conflicting write from idle.
  task automatic do_read(input logic [7:0] a, input int n, input bit wiggle,
                         input bit fin, input logic [7:0] ca, input logic [3:0] cd);
    logic [7:0] ai;
    for (int i = 1; i <= n; i++) begin
      ai = (i == 1 || !wiggle) ? a : 8'($urandom);
      cyc(1'b0, 1'b1, 1'b0, ai, 4'($urandom));
      for (int dd = 0; dd < 2; dd++) begin
        if (i > skip(dd)) push(dd, mdl_mem[dd][ai]);
      end
    end
    if (fin) cyc(1'b0, 1'b0, 1'b0, ca, cd);
    for (int dd = 0; dd < 2; dd++) begin
      if (n >= rl[dd] + 1) inc_r(dd);
      if (fin) begin
        mcf[dd] = 1;
        // The write commits from idle or from an active drive, but not
        // from a pending wait.
        if (n == 0 || n >= rl[dd] + 1) begin
          mdl_mem[dd][ca] = cd;
          inc_w(dd);
        end
      end
    end
    idle_check();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    flag_fail("timeout");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "simulation did not finish");
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int dd = 0; dd < 2; dd++) begin
      mwc[dd] = 0; mrc[dd] = 0; mcf[dd] = 0;
    end

    // The pins request a read while reset is held; neither device may drive.
    p_cs = 1'b0; p_we = 1'b1; p_oe = 1'b0;
    #12;
    check("rst_drive0", if0.data_drive_en, 0);
    check("rst_drive1", if1.data_drive_en, 0);
    check("rst_wc0", wc0, 0);
    check("rst_rc0", rc0, 0);
    check("rst_cf0", cf0, 0);
    check("rst_wc1", wc1, 0);
    check("rst_rc1", rc1, 0);
    check("rst_cf1", cf1, 0);
    p_cs = 1'b1; p_oe = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Write, then read back.
    do_write(8'h3C, 4'hA, 1, 1'b0);
    do_read(8'h3C, 2, 1'b0, 1'b0, 8'h00, 4'h0);
    // WE held for 4 cycles while the data changes; only 0x1 is kept.
    do_write(8'h10, 4'h1, 4, 1'b0);
    do_read(8'h10, 4, 1'b0, 1'b0, 8'h00, 4'h0);
    // Conflicting write from idle, then read back.
    do_read(8'h00, 0, 1'b0, 1'b1, 8'h05, 4'h7);
    do_read(8'h05, 2, 1'b0, 1'b0, 8'h00, 4'h0);
    // Latency behaviour at 0xFF: a long read, then a read aborted after one edge.
    do_write(8'hFF, 4'h9, 1, 1'b0);
    do_read(8'hFF, 5, 1'b0, 1'b0, 8'h00, 4'h0);
    do_read(8'hFF, 1, 1'b0, 1'b0, 8'h00, 4'h0);

    // Reset in the middle of an active drive.
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h3C, 4'h0);
      for (int dd = 0; dd < 2; dd++) begin
        if (i > skip(dd)) push(dd, mdl_mem[dd][8'h3C]);
      end
    end
    @(posedge clk);
    #1;
    check("pre_rst_drive0", if0.data_drive_en, 1);
    check("pre_rst_drive1", if1.data_drive_en, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_drive0", if0.data_drive_en, 0);
    check("mid_rst_drive1", if1.data_drive_en, 0);
    check("mid_rst_wc0", wc0, 0);
    check("mid_rst_rc0", rc0, 0);
    check("mid_rst_cf0", cf0, 0);
    check("mid_rst_cf1", cf1, 0);
    for (int dd = 0; dd < 2; dd++) begin
      mwc[dd] = 0; mrc[dd] = 0; mcf[dd] = 0;
    end
    @(negedge clk);
    p_cs = 1'b1; p_oe = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    do_read(8'h3C, 4, 1'b0, 1'b0, 8'h00, 4'h0);
    do_read(8'h05, 4, 1'b0, 1'b0, 8'h00, 4'h0);

    // Fill the whole array. dut1's write counter saturates along the way.
    for (int a = 0; a < 256; a++) begin
      do_write(8'(a), 4'($urandom), 1, 1'b0);
    end

    // Random mix of transactions.
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_write(8'($urandom), 4'($urandom), $urandom_range(1, 3), 1'($urandom));
      end else begin
        int  n;
        bit  fin;
        n   = $urandom_range(0, 6);
        fin = ($urandom_range(0, 3) == 0) || (n == 0);
        do_read(8'($urandom), n, 1'($urandom), fin, 8'($urandom), 4'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable model of a 256x4 asynchronous SRAM device, acting as the responding end of the SRAM pin interface (address pins, data pins, OE/WE/CS, all active-low).
- Decodes pin-level strobes into memory writes and read data drive.
- Counts completed accesses and flags protocol conflicts.
- Used as the on-chip/FPGA stand-in for the external SRAM and as the bench target for the SRAM controller.

Parameters:
ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
DATA_W, 4, data word width
READ_LATENCY, 0, wait cycles between read request and data drive (0..7)
COUNT_W, 16, width of access counters

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
address_pins  input  ADDR_W  word address from controller
data_pins_in  input  DATA_W  write data driven by controller
OE  input  1  output enable, low active
WE  input  1  write enable, low active
CS  input  1  chip select, low active
data_pins_out  output  DATA_W  read data toward controller
data_drive_en  output  1  high when responder drives data pins
write_count  output  COUNT_W  completed write accesses, saturating
read_count  output  COUNT_W  completed read accesses, saturating
conflict  output  1  sticky: WE and OE sampled low together with CS low

Behaviour:
- Reset (reset low, async):
  - state=IDLE, wait_cnt=0, write_count=0, read_count=0, conflict=0.
  - data_drive_en=0 immediately.
  - Memory array is not cleared; contents are undefined until written.
- Sampling: CS/WE/OE/address/data are sampled on each rising clock edge, with no extra synchronizer (same clock domain as controller).
- Memory read is asynchronous: data_pins_out = mem[address_pins] at all times.
- States: IDLE, WRITE_HOLD, READ_WAIT, READ_DRIVE.
- Every state: sampled CS=1 -> IDLE. Takes priority over all other transitions; no commit, no count.
- IDLE:
  - CS=0, WE=0: commit mem[address_pins] <= data_pins_in at that edge, write_count+1 -> WRITE_HOLD.
  - If OE=0 at the same edge, also set conflict; write wins and no read is started.
  - CS=0, WE=1, OE=0, READ_LATENCY=0: read_count+1 -> READ_DRIVE.
  - CS=0, WE=1, OE=0, READ_LATENCY>0: wait_cnt=READ_LATENCY-1 -> READ_WAIT.
- WRITE_HOLD:
  - Exactly one commit per WE low pulse; WE held low for multiple cycles never re-commits, even if address/data change.
  - WE=1 -> IDLE; a new request is evaluated at the next edge.
- READ_WAIT:
  - OE=1 or WE=0 -> IDLE, no count. If WE=0 with OE=0, set conflict but do not commit.
  - wait_cnt==0 -> READ_DRIVE, read_count+1; else wait_cnt-1.
- READ_DRIVE:
  - Stay while CS=0, OE=0, WE=1. Data follows address_pins combinationally; address changes do not re-count.
  - OE=1 -> IDLE.
  - WE=0 with OE=0: set conflict, commit write, write_count+1 -> WRITE_HOLD.
- data_drive_en (combinational from pins, qualified by state):
  - Equation: (!CS & !OE & WE) & (state==READ_DRIVE | (READ_LATENCY==0 & state==IDLE)).
  - With READ_LATENCY=0, data is valid in the same cycle OE/CS go low, so a controller sampling one edge after asserting OE/CS captures correct data.
  - Deasserts in the same cycle that CS or OE rises, or WE falls.
- Counters: increment by 1 per access, saturate at 2**COUNT_W-1, never wrap.
- conflict: cleared only by reset.
- Reset mid-access: an in-flight write that has already committed stays committed. data_drive_en drops immediately on reset assertion.

Test Plan:
- Write pulse (CS low 2 cycles, WE low 1 cycle) addr 0x3C data 0xA, then read (CS/OE low 2 cycles) -> at READ_LATENCY=0, data_drive_en high in the first OE-low cycle, data_pins_out=0xA; write_count=1, read_count=1.
- WE held low 4 cycles at addr 0x10 while data changes 0x1->0x2->0x3->0x4 -> mem[0x10]=0x1, write_count=1.
- CS=0, WE=0, OE=0 at addr 0x05 data 0x7 -> conflict=1, mem[0x05]=0x7, data_drive_en stays 0, read_count unchanged. conflict stays 1 until reset low.
- READ_LATENCY=2, read of addr 0xFF holding 0x9 -> data_drive_en low for 2 edges, high from the 3rd edge with 0x9. OE raised after 1 edge instead -> no drive, read_count unchanged.
- reset driven low mid-READ_DRIVE -> data_drive_en=0 in the same cycle, counters=0. A previously written addr still reads back its value after reset releases.
- COUNT_W=4, 17 write pulses -> write_count saturates at 15.
